// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one external multiplier among NUM_REQ requesters.
// A tag pipeline matched to the multiplier latency routes each product back to its issuer.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]       rsp_data,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [2*WIDTH-1:0]       mul_p,
  output logic                     busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int SUM_W = PTR_W + 1;
  localparam int DEPTH = LATENCY + 1;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = {NUM_REQ{1'b0}};
    v[id] = 1'b1;
    return v;
  endfunction

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   off;
  logic [PTR_W-1:0]   grant_id;
  logic [PTR_W-1:0]   ptr_next;
  logic [SUM_W-1:0]   sum;
  logic [SUM_W-1:0]   gid_inc;
  logic [NUM_REQ-1:0] rot;
  logic               found;
  logic               xfer;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [DEPTH-1:0]   tag_valid;
  logic [DEPTH-1:0]   tv_next;
  logic [PTR_W-1:0]   tag_id [DEPTH];

  // Rotate requests so bit 0 is the current priority holder, then take the first set bit.
  always_comb begin
    rot   = NUM_REQ'({req_valid, req_valid} >> ptr);
    off   = {PTR_W{1'b0}};
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      off   = (rot[k] && !found) ? PTR_W'(k) : off;
      found = found | rot[k];
    end
    sum       = {1'b0, ptr} + {1'b0, off};
    grant_id  = (sum >= SUM_W'(NUM_REQ)) ? PTR_W'(sum - SUM_W'(NUM_REQ)) : sum[PTR_W-1:0];
    xfer      = found & ~rst;
    req_ready = xfer ? onehot(grant_id) : {NUM_REQ{1'b0}};
    gid_inc   = {1'b0, grant_id} + {{PTR_W{1'b0}}, 1'b1};
    ptr_next  = (gid_inc >= SUM_W'(NUM_REQ)) ? {PTR_W{1'b0}} : gid_inc[PTR_W-1:0];
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = {WIDTH{1'b0}};
    sel_b = {WIDTH{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_a = (grant_id == PTR_W'(k)) ? req_a[k*WIDTH +: WIDTH] : sel_a;
      sel_b = (grant_id == PTR_W'(k)) ? req_b[k*WIDTH +: WIDTH] : sel_b;
    end
  end

  // Next tag-valid vector: a transfer enters stage 0, everything else shifts one stage.
  always_comb begin
    tv_next    = {DEPTH{1'b0}};
    tv_next[0] = xfer;
    for (int k = 1; k < DEPTH; k++) begin
      tv_next[k] = tag_valid[k-1];
    end
  end

  // Pointer and multiplier operands advance only on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= {PTR_W{1'b0}};
      mul_a <= {WIDTH{1'b0}};
      mul_b <= {WIDTH{1'b0}};
    end else if (xfer) begin
      ptr   <= ptr_next;
      mul_a <= sel_a;
      mul_b <= sel_b;
    end
  end

  // Tag shift register aligned with the multiplier pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        tag_id[k] <= {PTR_W{1'b0}};
      end
    end else begin
      tag_valid <= tv_next;
      tag_id[0] <= grant_id;
      for (int k = 1; k < DEPTH; k++) begin
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  // Response capture; rsp_data keeps the last product between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= {NUM_REQ{1'b0}};
      rsp_data  <= {(2*WIDTH){1'b0}};
      busy      <= 1'b0;
    end else begin
      rsp_valid <= tag_valid[LATENCY] ? onehot(tag_id[LATENCY]) : {NUM_REQ{1'b0}};
      if (tag_valid[LATENCY]) begin
        rsp_data <= mul_p;
      end
      busy <= |tv_next;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench: three arbiter instances (LATENCY 0, 2, 3) share one request stream,
// each with its own multiplier model; responses are checked against hand-computed products.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;

  logic [3:0]  rdy0, rv0, rdy2, rv2, rdy3, rv3;
  logic [31:0] rd0, rd2, rd3, mp0, mp2, mp3;
  logic [15:0] ma0, mb0, ma2, mb2, ma3, mb3;
  logic        bsy0, bsy2, bsy3;
  logic [31:0] p2_s1, p2_s2, p3_s1, p3_s2, p3_s3;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [3:0]  exp_oh [256];
  logic [31:0] exp_pr [256];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mult_share_arbiter #(.NUM_REQ(4), .WIDTH(16), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rv0), .rsp_data(rd0), .mul_a(ma0), .mul_b(mb0), .mul_p(mp0), .busy(bsy0));
  mult_share_arbiter #(.NUM_REQ(4), .WIDTH(16), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rv2), .rsp_data(rd2), .mul_a(ma2), .mul_b(mb2), .mul_p(mp2), .busy(bsy2));
  mult_share_arbiter #(.NUM_REQ(4), .WIDTH(16), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rv3), .rsp_data(rd3), .mul_a(ma3), .mul_b(mb3), .mul_p(mp3), .busy(bsy3));

  assign mp0 = {16'b0, ma0} * {16'b0, mb0};
  assign mp2 = p2_s2;
  assign mp3 = p3_s3;

  always @(posedge clk) begin
    p2_s1 <= {16'b0, ma2} * {16'b0, mb2};
    p2_s2 <= p2_s1;
    p3_s1 <= {16'b0, ma3} * {16'b0, mb3};
    p3_s2 <= p3_s1;
    p3_s3 <= p3_s2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic dut_chk(input string nm, input int lat, input logic [3:0] rdy,
                         input logic [3:0] rv, input logic [31:0] rd, input logic [3:0] er);
    int         idx;
    logic [3:0] e;
    idx = cyc - lat - 2;
    e   = (idx >= 0) ? exp_oh[idx[7:0]] : 4'b0000;
    chk({nm, "_req_ready"}, {28'b0, rdy}, {28'b0, er});
    chk({nm, "_rsp_valid"}, {28'b0, rv}, {28'b0, e});
    if (e != 4'b0000) chk({nm, "_rsp_data"}, rd, exp_pr[idx[7:0]]);
  endtask

  // One clock: drive valid, check grant and due responses at negedge, record the issue.
  task automatic tick(input logic [3:0] v, input logic [3:0] er, input logic [31:0] ep);
    req_valid = v;
    @(negedge clk);
    dut_chk("L0", 0, rdy0, rv0, rd0, er);
    dut_chk("L2", 2, rdy2, rv2, rd2, er);
    dut_chk("L3", 3, rdy3, rv3, rd3, er);
    exp_oh[cyc[7:0]] = er;
    exp_pr[cyc[7:0]] = ep;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(4'b0000, 4'b0000, 32'd0);
  endtask

  task automatic chk_quiet(input string nm, input logic [31:0] rd, input logic [15:0] ma,
                           input logic [15:0] mb, input logic b, input logic [31:0] erd);
    chk({nm, "_rsp_data"}, rd, erd);
    chk({nm, "_mul_a"}, {16'b0, ma}, 32'd0);
    chk({nm, "_mul_b"}, {16'b0, mb}, 32'd0);
    chk({nm, "_busy"}, {31'b0, b}, 32'd0);
  endtask

  initial begin
    for (int j = 0; j < 256; j++) begin
      exp_oh[j] = 4'b0000;
      exp_pr[j] = 32'd0;
    end
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_a     = 64'd0;
    req_b     = 64'd0;

    // Reset: grants suppressed, outputs cleared.
    tick(4'b1111, 4'b0000, 32'd0);
    chk_quiet("rst_L0", rd0, ma0, mb0, bsy0, 32'd0);
    chk_quiet("rst_L2", rd2, ma2, mb2, bsy2, 32'd0);
    chk_quiet("rst_L3", rd3, ma3, mb3, bsy3, 32'd0);
    rst = 1'b0;

    // Single request from requester 0: 37*42 = 1554.
    set_op(0, 16'd37, 16'd42);
    tick(4'b0001, 4'b0001, 32'd1554);
    idle(2);
    chk("busy_inflight_L2", {31'b0, bsy2}, 32'd1);
    chk("busy_inflight_L3", {31'b0, bsy3}, 32'd1);
    idle(4);
    chk("busy_idle_L0", {31'b0, bsy0}, 32'd0);
    chk("busy_idle_L2", {31'b0, bsy2}, 32'd0);
    chk("busy_idle_L3", {31'b0, bsy3}, 32'd0);
    chk("hold_L0", rd0, 32'd1554);
    chk("hold_L3", rd3, 32'd1554);

    // ptr=1, only requester 3: 0 x 0x1234 = 0; ptr wraps to 0.
    set_op(3, 16'h0000, 16'h1234);
    tick(4'b1000, 4'b1000, 32'd0);

    // All four valid: grants 0,1,2,3,0,1 with back-to-back responses.
    set_op(0, 16'd3, 16'd5);
    set_op(1, 16'd7, 16'd11);
    set_op(2, 16'd100, 16'd200);
    set_op(3, 16'hFFFF, 16'hFFFF);
    tick(4'b1111, 4'b0001, 32'd15);
    tick(4'b1111, 4'b0010, 32'd77);
    tick(4'b1111, 4'b0100, 32'd20000);
    tick(4'b1111, 4'b1000, 32'hFFFE0001);
    tick(4'b1111, 4'b0001, 32'd15);
    tick(4'b1111, 4'b0010, 32'd77);

    // ptr=2, requesters 0 and 3: grant 3 then 0.
    tick(4'b1001, 4'b1000, 32'hFFFE0001);
    tick(4'b0001, 4'b0001, 32'd15);

    // ptr=1: requester 1 wins over 2; requester 2 then withdraws; ptr stays 2.
    tick(4'b0110, 4'b0010, 32'd77);
    tick(4'b0000, 4'b0000, 32'd0);
    tick(4'b1011, 4'b1000, 32'hFFFE0001);
    idle(5);

    // Two issues, then reset before the LATENCY=3 responses; they must vanish.
    tick(4'b0011, 4'b0001, 32'd15);
    tick(4'b0011, 4'b0010, 32'd77);
    tick(4'b0000, 4'b0000, 32'd0);
    rst = 1'b1;
    for (int j = 0; j < 256; j++) exp_oh[j] = 4'b0000;
    tick(4'b1111, 4'b0000, 32'd0);
    rst = 1'b0;
    chk_quiet("post_rst_L0", rd0, ma0, mb0, bsy0, 32'd0);
    chk_quiet("post_rst_L2", rd2, ma2, mb2, bsy2, 32'd0);
    chk_quiet("post_rst_L3", rd3, ma3, mb3, bsy3, 32'd0);
    idle(6);

    // First grant after reset goes to the lowest index.
    tick(4'b1111, 4'b0001, 32'd15);
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
